// File: rtl/fsm_state_stage.sv
// State/routing stage of the programmable FSM: serial config chain, AND-input source muxes
// and the state register. Optional macro FSM_STEP_CNT_EN adds a saturating step counter.
module fsm_state_stage #(
   parameter int unsigned STATE_BITS = 2,
   parameter int unsigned IN_BITS    = 2,
   parameter int unsigned UNITS      = 2,
   parameter int unsigned SELW       = 4,
   localparam int unsigned NTERM     = STATE_BITS * UNITS * 4,
   localparam int unsigned CFG_LEN   = NTERM * SELW + STATE_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_en,
   input  logic                  cfg_in,
   output logic                  cfg_out,
   input  logic                  start,
   input  logic                  run,
   input  logic                  step,
   input  logic [IN_BITS-1:0]    fsm_in,
   output logic [NTERM-1:0]      terms,
   input  logic [STATE_BITS-1:0] next_state,
`ifdef FSM_STEP_CNT_EN
   output logic [7:0]            step_cnt,
`endif
   output logic [STATE_BITS-1:0] state_q
);

   localparam int unsigned NSRC = 2 * (1 + STATE_BITS + IN_BITS);

   logic [CFG_LEN-1:0]    chain_q;
   logic [IN_BITS-1:0]    in_q;
   logic [STATE_BITS-1:0] state_d;
   logic                  advance;
   // Padded to the full select range so unused codes read as 0.
   logic [2**SELW-1:0]    src;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
         in_q    <= '0;
         state_q <= '0;
      end else begin
         if (cfg_en) begin
            chain_q <= {chain_q[CFG_LEN-2:0], cfg_in};
         end
         in_q    <= fsm_in;
         state_q <= state_d;
      end
   end

   assign cfg_out = chain_q[CFG_LEN-1];

   always_comb begin
      state_d = state_q;
      advance = 1'b0;
      if (!cfg_en) begin
         if (start) begin
            state_d = chain_q[STATE_BITS-1:0];
         end else if (run || step) begin
            state_d = next_state;
            advance = 1'b1;
         end
      end
   end

   always_comb begin
      src = '0;
      src[1] = 1'b1;
      src[2 +: STATE_BITS]                        = state_q;
      src[2 + STATE_BITS +: IN_BITS]              = in_q;
      src[2 + STATE_BITS + IN_BITS +: STATE_BITS] = ~state_q;
      src[2 + 2 * STATE_BITS + IN_BITS +: IN_BITS] = ~in_q;
      terms = '0;
      for (int t = 0; t < NTERM; t++) begin
         terms[t] = src[chain_q[STATE_BITS + t * SELW +: SELW]];
      end
   end

`ifdef FSM_STEP_CNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!cfg_en && start) begin
         cnt_q <= '0;
      end else if (advance && cnt_q != 8'hff) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign step_cnt = cnt_q;
`else
   logic unused_advance;
   assign unused_advance = advance;
`endif

   logic unused_src;
   assign unused_src = ^src[2**SELW-1:NSRC];

endmodule

// File: tb/tb_fsm_state_stage.sv
// Directed bench for fsm_state_stage; models the fsm_unit AND-OR chains externally.
// Exercises the step counter too when FSM_STEP_CNT_EN is defined.
module tb_fsm_state_stage;

   localparam int NTERM   = 16;
   localparam int CFG_LEN = 66;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_en = 1'b0;
   logic             cfg_in = 1'b0;
   logic             cfg_out;
   logic             start = 1'b0;
   logic             run = 1'b0;
   logic             step = 1'b0;
   logic [1:0]       fsm_in = 2'b00;
   logic [NTERM-1:0] terms;
   logic [1:0]       next_state;
   logic [1:0]       state_q;
`ifdef FSM_STEP_CNT_EN
   logic [7:0]       step_cnt;
`endif

   int checks = 0;
   int errors = 0;

   fsm_state_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_en     (cfg_en),
      .cfg_in     (cfg_in),
      .cfg_out    (cfg_out),
      .start      (start),
      .run        (run),
      .step       (step),
      .fsm_in     (fsm_in),
      .terms      (terms),
      .next_state (next_state),
`ifdef FSM_STEP_CNT_EN
      .step_cnt   (step_cnt),
`endif
      .state_q    (state_q)
   );

   always #5 clk = ~clk;

   // fsm_unit model: or2out = (and11 & and12) | (and21 & and22), ORed along the chain.
   always_comb begin
      next_state = '0;
      for (int b = 0; b < 2; b++) begin
         for (int u = 0; u < 2; u++) begin
            next_state[b] = next_state[b]
               | (terms[(b*2+u)*4+0] & terms[(b*2+u)*4+1])
               | (terms[(b*2+u)*4+2] & terms[(b*2+u)*4+3]);
         end
      end
   end

   typedef struct {
      logic [3:0] sel;
      logic [1:0] st;
      logic [1:0] inp;
      logic       exp;
   } vec_t;

   vec_t vecs[24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CFG_LEN-1:0] mk_cfg(input logic [1:0] init, input logic [3:0] s0,
                                                 input logic [3:0] s1, input logic [3:0] s15);
      logic [CFG_LEN-1:0] v;
      v = '0;
      v[1:0]      = init;
      v[2 +: 4]   = s0;
      v[6 +: 4]   = s1;
      v[62 +: 4]  = s15;
      return v;
   endfunction

   // MSB goes in first so it ends up at the chain tail.
   task automatic load_cfg(input logic [CFG_LEN-1:0] v);
      cfg_en = 1'b1;
      for (int i = CFG_LEN - 1; i >= 0; i--) begin
         cfg_in = v[i];
         tick();
      end
      cfg_en = 1'b0;
      cfg_in = 1'b0;
   endtask

   initial begin
      // Pattern A: state=01, in=10; pattern B: state=10, in=01.
      vecs[0]  = '{4'd0,  2'b01, 2'b10, 1'b0};
      vecs[1]  = '{4'd1,  2'b01, 2'b10, 1'b1};
      vecs[2]  = '{4'd2,  2'b01, 2'b10, 1'b1};
      vecs[3]  = '{4'd3,  2'b01, 2'b10, 1'b0};
      vecs[4]  = '{4'd4,  2'b01, 2'b10, 1'b0};
      vecs[5]  = '{4'd5,  2'b01, 2'b10, 1'b1};
      vecs[6]  = '{4'd6,  2'b01, 2'b10, 1'b0};
      vecs[7]  = '{4'd7,  2'b01, 2'b10, 1'b1};
      vecs[8]  = '{4'd8,  2'b01, 2'b10, 1'b1};
      vecs[9]  = '{4'd9,  2'b01, 2'b10, 1'b0};
      vecs[10] = '{4'd10, 2'b01, 2'b10, 1'b0};
      vecs[11] = '{4'd11, 2'b11, 2'b11, 1'b0};
      vecs[12] = '{4'd12, 2'b11, 2'b11, 1'b0};
      vecs[13] = '{4'd13, 2'b00, 2'b00, 1'b0};
      vecs[14] = '{4'd14, 2'b00, 2'b00, 1'b0};
      vecs[15] = '{4'd15, 2'b00, 2'b00, 1'b0};
      vecs[16] = '{4'd2,  2'b10, 2'b01, 1'b0};
      vecs[17] = '{4'd3,  2'b10, 2'b01, 1'b1};
      vecs[18] = '{4'd4,  2'b10, 2'b01, 1'b1};
      vecs[19] = '{4'd5,  2'b10, 2'b01, 1'b0};
      vecs[20] = '{4'd6,  2'b10, 2'b01, 1'b1};
      vecs[21] = '{4'd7,  2'b10, 2'b01, 1'b0};
      vecs[22] = '{4'd8,  2'b10, 2'b01, 1'b0};
      vecs[23] = '{4'd9,  2'b10, 2'b01, 1'b1};

      // Reset state
      #12;
      chk("reset_state", 32'(state_q), 32'd0);
      chk("reset_terms", 32'(terms), 32'd0);
      chk("reset_cfg_out", 32'(cfg_out), 32'd0);
      rst_n = 1'b1;
      tick();

      // Source decode table
      for (int i = 0; i < 24; i++) begin
         fsm_in = vecs[i].inp;
         load_cfg(mk_cfg(vecs[i].st, vecs[i].sel, 4'd0, 4'd0));
         start = 1'b1;
         tick();
         start = 1'b0;
         chk($sformatf("init_v%0d", i), 32'(state_q), 32'(vecs[i].st));
         chk($sformatf("decode_v%0d", i), 32'(terms[0]), 32'(vecs[i].exp));
      end

      // Toggle FSM: q0 <= ~q0, q1 stays 0
      fsm_in = 2'b00;
      load_cfg(mk_cfg(2'b00, 4'd6, 4'd1, 4'd0));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("toggle_start", 32'(state_q), 32'd0);
      run = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk($sformatf("toggle_%0d", i), 32'(state_q), 32'(i % 2));
      end

      // cfg_en freezes state even with run=1 (state would otherwise drop to 00)
      cfg_en = 1'b1;
      cfg_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("freeze_%0d", i), 32'(state_q), 32'd1);
      end
      load_cfg(mk_cfg(2'b10, 4'd6, 4'd1, 4'd0));
      chk("freeze_load", 32'(state_q), 32'd1);

      // start beats run
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_over_run", 32'(state_q), 32'd2);
      tick();
      chk("run_after_start", 32'(state_q), 32'd1);
      run = 1'b0;
      tick();
      chk("hold_idle", 32'(state_q), 32'd1);

      // step is a level qualifier
      step = 1'b1;
      tick();
      tick();
      tick();
      step = 1'b0;
      chk("step_x3", 32'(state_q), 32'd0);

      // Input path latency: q0 <= in_q[0]
      fsm_in = 2'b00;
      load_cfg(mk_cfg(2'b00, 4'd4, 4'd1, 4'd0));
      start = 1'b1;
      tick();
      start = 1'b0;
      run = 1'b1;
      tick();
      tick();
      fsm_in = 2'b01;
      chk("in_term_before", 32'(terms[0]), 32'd0);
      tick();
      chk("in_term_after", 32'(terms[0]), 32'd1);
      chk("in_state_n1", 32'(state_q), 32'd0);
      tick();
      chk("in_state_n2", 32'(state_q), 32'd1);
      run = 1'b0;

      // Async reset mid-run
      fsm_in = 2'b00;
      load_cfg(mk_cfg(2'b11, 4'd0, 4'd1, 4'd8));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("pre_rst_state", 32'(state_q), 32'd3);
      chk("pre_rst_terms", 32'(terms), 32'h8002);
      chk("pre_rst_cfg_out", 32'(cfg_out), 32'd1);
      run = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", 32'(state_q), 32'd0);
      chk("async_rst_terms", 32'(terms), 32'd0);
      chk("async_rst_cfg_out", 32'(cfg_out), 32'd0);
      run = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("post_rst_init", 32'(state_q), 32'd0);
      chk("post_rst_terms", 32'(terms), 32'd0);

      // Chain pass-through
      cfg_en = 1'b1;
      cfg_in = 1'b1;
      for (int i = 1; i <= CFG_LEN; i++) begin
         tick();
         if (i == CFG_LEN - 1) chk("chain_65", 32'(cfg_out), 32'd0);
         if (i == CFG_LEN) chk("chain_66", 32'(cfg_out), 32'd1);
      end
      cfg_in = 1'b0;
      tick();
      cfg_en = 1'b0;
      chk("chain_67", 32'(cfg_out), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("chain_init", 32'(state_q), 32'd2);

`ifdef FSM_STEP_CNT_EN
      load_cfg(mk_cfg(2'b00, 4'd6, 4'd1, 4'd0));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("cnt_after_start", 32'(step_cnt), 32'd0);
      run = 1'b1;
      for (int i = 0; i < 300; i++) tick();
      run = 1'b0;
      chk("cnt_saturate", 32'(step_cnt), 32'd255);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("cnt_clear", 32'(step_cnt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         tick();
      end
      chk("cnt_steps", 32'(step_cnt), 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
